filter_buffer_5x5: RTL and testbench

Registered 5x5 convolution-filter store for the CNN datapath. It captures a full 25-tap signed 16-bit filter from the weight-loading path on a read strobe, holds it for the convolution engine, and signals capture completion with a level `finish` flag.

---
 rtl/filter_buffer_5x5_if.sv | 44 ++++
 rtl/filter_buffer_5x5.sv | 69 ++++++
 tb/tb_filter_buffer_5x5.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/filter_buffer_5x5_if.sv
// Bundle between the weight-loading path (master) and the 5x5 filter store (slave).
// FILTER_BUFFER_CHECKSUM_EN adds the registered checksum signal.
interface filter_buffer_5x5_if #(
    parameter int N      = 5,
    parameter int DATA_W = 16
);
    logic                     read;
    logic signed [DATA_W-1:0] input_filter  [N-1:0][N-1:0];
    logic                     finish;
    logic signed [DATA_W-1:0] output_filter [N-1:0][N-1:0];
`ifdef FILTER_BUFFER_CHECKSUM_EN
    logic signed [DATA_W+4:0] checksum;

    modport master (
        output read,
        output input_filter,
        input  finish,
        input  output_filter,
        input  checksum
    );

    modport slave (
        input  read,
        input  input_filter,
        output finish,
        output output_filter,
        output checksum
    );
`else
    modport master (
        output read,
        output input_filter,
        input  finish,
        input  output_filter
    );

    modport slave (
        input  read,
        input  input_filter,
        output finish,
        output output_filter
    );
`endif
endinterface

// File: rtl/filter_buffer_5x5.sv
// Registered 5x5 signed filter store. A high `read` at a rising edge captures
// all taps and raises `finish` for that cycle; otherwise the taps hold.
// Optional: define FILTER_BUFFER_CHECKSUM_EN to add a registered signed sum
// of the captured taps (DATA_W+5 bits, cannot overflow for 25 taps).
module filter_buffer_5x5 #(
    parameter int N      = 5,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    filter_buffer_5x5_if.slave  bus
);

    logic signed [DATA_W-1:0] taps [N-1:0][N-1:0];
    logic                     finish_q;

    // Tap storage and completion flag; finish is read delayed by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    taps[r][c] <= '0;
                end
            end
            finish_q <= 1'b0;
        end else begin
            finish_q <= bus.read;
            if (bus.read) begin
                for (int unsigned r = 0; r < N; r++) begin
                    for (int unsigned c = 0; c < N; c++) begin
                        taps[r][c] <= bus.input_filter[r][c];
                    end
                end
            end
        end
    end

    assign bus.output_filter = taps;
    assign bus.finish        = finish_q;

`ifdef FILTER_BUFFER_CHECKSUM_EN
    localparam int CSUM_W = DATA_W + 5;

    logic signed [CSUM_W-1:0] sum_next;
    logic signed [CSUM_W-1:0] csum_q;

    // Sign-extended sum of the incoming taps, ready to be captured with them.
    always_comb begin
        sum_next = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                sum_next = sum_next + CSUM_W'(bus.input_filter[r][c]);
            end
        end
    end

    // Checksum register, loaded on the same edge as the taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (bus.read) begin
            csum_q <= sum_next;
        end
    end

    assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_filter_buffer_5x5.sv
// Self-checking bench for filter_buffer_5x5: directed vectors, a flat
// integer model compared every cycle, and literal expectations.
// Define FILTER_BUFFER_CHECKSUM_EN to also check the checksum output.
module tb_filter_buffer_5x5;
    localparam int N      = 5;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;

    filter_buffer_5x5_if #(.N(N), .DATA_W(DATA_W)) bus ();

    filter_buffer_5x5 #(.N(N), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: flat list of 25 stored tap values plus the finish level.
    int m_tap [N*N];
    int m_fin;
    int cur   [N][N];

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (m_tap[i]) s += m_tap[i];
        return s;
    endfunction

    initial begin
        foreach (m_tap[i]) m_tap[i] = 0;
        m_fin = 0;
    end

    always @(negedge rst_n) begin
        foreach (m_tap[i]) m_tap[i] = 0;
        m_fin = 0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_fin = (bus.read === 1'b1) ? 1 : 0;
            if (bus.read === 1'b1) begin
                for (int i = 0; i < N*N; i++) m_tap[i] = int'(bus.input_filter[i / N][i % N]);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    check($sformatf("model_tap[%0d][%0d]", r, c),
                          32'(bus.output_filter[r][c]), m_tap[r*N + c]);
                end
            end
            check("model_finish", 32'(bus.finish), m_fin);
`ifdef FILTER_BUFFER_CHECKSUM_EN
            check("model_checksum", 32'(bus.checksum), model_sum());
`endif
        end
    end

    task automatic drive_cur();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.input_filter[r][c] = DATA_W'(cur[r][c]);
    endtask

    task automatic set_all(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cur[r][c] = v;
        drive_cur();
    endtask

    task automatic set_pattern(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cur[r][c] = base + r*5 + c;
        drive_cur();
    endtask

    task automatic check_taps(input string name, input int base, input int all_same, input bit use_all);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check($sformatf("%s[%0d][%0d]", name, r, c), 32'(bus.output_filter[r][c]),
                      use_all ? all_same : base + r*5 + c);
    endtask

    initial begin
        rst_n    = 1'b1;
        bus.read = 1'b1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cur[r][c] = int'($urandom_range(0, 1000)) - 500;
        drive_cur();

        // Reset asserted between edges with random data and read high.
        #2 rst_n = 1'b0;
        #1;
        check("reset_finish", 32'(bus.finish), 0);
        check_taps("reset_tap", 0, 0, 1'b1);
`ifdef FILTER_BUFFER_CHECKSUM_EN
        check("reset_checksum", 32'(bus.checksum), 0);
`endif
        repeat (3) @(negedge clk);
        check("reset_hold_finish", 32'(bus.finish), 0);
        check_taps("reset_hold_tap", 0, 0, 1'b1);
        cmp_en   = 1'b1;
        bus.read = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Single capture of 0..24.
        set_pattern(0);
        bus.read = 1'b1;
        @(negedge clk);
        check_taps("single_tap", 0, 0, 1'b0);
        check("single_finish", 32'(bus.finish), 1);
        bus.read = 1'b0;
        set_all(99);
        @(negedge clk);
        check("idle_finish", 32'(bus.finish), 0);
        check_taps("idle_tap", 0, 0, 1'b0);

        // Hold with changed inputs.
        repeat (10) @(negedge clk);
        check("hold_finish", 32'(bus.finish), 0);
        check_taps("hold_tap", 0, 0, 1'b0);

        // Random captures.
        for (int it = 0; it < 300; it++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    cur[r][c] = int'($urandom % 100);
            drive_cur();
            bus.read = 1'b1;
            @(negedge clk);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    check("rand_tap", 32'(bus.output_filter[r][c]), cur[r][c]);
            check("rand_finish_hi", 32'(bus.finish), 1);
            bus.read = 1'b0;
            @(negedge clk);
            check("rand_finish_lo", 32'(bus.finish), 0);
        end

        // Signed extremes.
        set_all(-32768);
        bus.read = 1'b1;
        @(negedge clk);
        check_taps("min_tap", 0, -32768, 1'b1);
`ifdef FILTER_BUFFER_CHECKSUM_EN
        check("min_checksum", 32'(bus.checksum), -819200);
`endif
        set_all(32767);
        @(negedge clk);
        check_taps("max_tap", 0, 32767, 1'b1);
`ifdef FILTER_BUFFER_CHECKSUM_EN
        check("max_checksum", 32'(bus.checksum), 819175);
`endif
        bus.read = 1'b0;
        @(negedge clk);
        check("max_hold_tap", 32'(bus.output_filter[4][4]), 32767);

        // Mid-operation reset pulse between edges.
        set_pattern(100);
        bus.read = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_finish", 32'(bus.finish), 0);
        check_taps("midrst_tap", 0, 0, 1'b1);
`ifdef FILTER_BUFFER_CHECKSUM_EN
        check("midrst_checksum", 32'(bus.checksum), 0);
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_taps("recap_tap", 100, 0, 1'b0);
        check("recap_finish", 32'(bus.finish), 1);
        bus.read = 1'b0;
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
